// File: rtl/dma_copy_engine_if.sv
// Bus bundle for dma_copy_engine: host control/status plus the single data-memory port.
// The Checksum signal exists only when DMA_CHECKSUM_EN is defined.
interface dma_copy_engine_if #(
    parameter int LEN_WIDTH = 16
);
    logic                 start;
    logic                 abort;
    logic [31:0]          Src_Address;
    logic [31:0]          Dst_Address;
    logic [LEN_WIDTH-1:0] Length;
    logic [31:0]          Address;
    logic [31:0]          Write_Data;
    logic [31:0]          Read_Data;
    logic                 DataMemory_Read;
    logic                 DataMemory_Write;
    logic                 busy;
    logic                 done;
    logic                 aborted;
    logic [LEN_WIDTH-1:0] Remaining;
`ifdef DMA_CHECKSUM_EN
    logic [31:0]          Checksum;
`endif

    // master is the copy engine, which masters the memory port; slave is host plus memory
    modport master (
        input  start, abort, Src_Address, Dst_Address, Length, Read_Data,
        output Address, Write_Data, DataMemory_Read, DataMemory_Write,
               busy, done, aborted, Remaining
`ifdef DMA_CHECKSUM_EN
        , output Checksum
`endif
    );

    modport slave (
        output start, abort, Src_Address, Dst_Address, Length, Read_Data,
        input  Address, Write_Data, DataMemory_Read, DataMemory_Write,
               busy, done, aborted, Remaining
`ifdef DMA_CHECKSUM_EN
        , input Checksum
`endif
    );
endinterface

// File: rtl/dma_copy_engine.sv
// Word-by-word memory copy engine: one read then one write per word (2 cycles/word).
// Optional feature macro DMA_CHECKSUM_EN adds a wrapping 32-bit sum of written words.
module dma_copy_engine #(
    parameter int LEN_WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    dma_copy_engine_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [31:0]          r_src;
    logic [31:0]          r_dst;
    logic [31:0]          r_buf;
    logic [LEN_WIDTH-1:0] r_remaining;
    logic                 r_aborted;
    logic                 w_accept;
    logic                 w_rd;
    logic                 w_wr;
    logic [31:0]          w_read_data;
`ifdef DMA_CHECKSUM_EN
    logic [31:0]          r_checksum;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort is only honoured in READ/WRITE; in IDLE a simultaneous start takes priority.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_rd     = 1'b0;
        w_wr     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = (bus.Length != '0) ? READ : FINISH;
                end
            end
            READ: begin
                w_rd   = 1'b1;
                w_next = bus.abort ? IDLE : WRITE;
            end
            WRITE: begin
                w_wr = 1'b1;
                if (bus.abort) begin
                    w_next = IDLE;
                end else if (r_remaining > LEN_WIDTH'(1)) begin
                    w_next = READ;
                end else begin
                    w_next = FINISH;
                end
            end
            FINISH: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_read_data = w_rd ? bus.Read_Data : 32'h0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_src       <= 32'h0;
            r_dst       <= 32'h0;
            r_buf       <= 32'h0;
            r_remaining <= '0;
            r_aborted   <= 1'b0;
`ifdef DMA_CHECKSUM_EN
            r_checksum  <= 32'h0;
`endif
        end else begin
            if (w_accept) begin
                r_src       <= bus.Src_Address & 32'hFFFF_FFFC;
                r_dst       <= bus.Dst_Address & 32'hFFFF_FFFC;
                r_remaining <= bus.Length;
                r_aborted   <= 1'b0;
`ifdef DMA_CHECKSUM_EN
                r_checksum  <= 32'h0;
`endif
            end
            if (w_rd) begin
                r_buf <= w_read_data;
            end
            // The write in progress always completes, even when abort arrives alongside it.
            if (w_wr) begin
                r_src       <= r_src + 32'd4;
                r_dst       <= r_dst + 32'd4;
                r_remaining <= r_remaining - LEN_WIDTH'(1);
`ifdef DMA_CHECKSUM_EN
                r_checksum  <= r_checksum + r_buf;
`endif
            end
            if ((w_rd || w_wr) && bus.abort) begin
                r_aborted <= 1'b1;
            end
        end
    end

    assign bus.Address          = w_rd ? r_src : (w_wr ? r_dst : 32'h0);
    assign bus.Write_Data       = w_wr ? r_buf : 32'h0;
    assign bus.DataMemory_Read  = w_rd;
    assign bus.DataMemory_Write = w_wr;
    assign bus.busy             = (r_state != IDLE);
    assign bus.done             = (r_state == FINISH);
    assign bus.aborted          = r_aborted;
    assign bus.Remaining        = r_remaining;
`ifdef DMA_CHECKSUM_EN
    assign bus.Checksum         = r_checksum;
`endif
endmodule

// File: tb/tb_dma_copy_engine.sv
// Scoreboard bench for dma_copy_engine: directed copies push expected writes into a queue,
// and an independent negedge monitor pops and compares every memory write the DUT issues.
module tb_dma_copy_engine;
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk;
   logic        rstN;
   logic        preloadEn;
   logic [9:0]  preloadIdx;
   logic [31:0] preloadData;
   logic [31:0] mem [0:1023];

   wr_t         expQ[$];
   logic [31:0] readLog[$];
   int          assertions = 0;
   int          failures = 0;
   int          readCount = 0;
   int          doneCount = 0;

   dma_copy_engine_if #(.LEN_WIDTH(16)) bus ();

   dma_copy_engine #(.LEN_WIDTH(16)) dut (
      .clk  (clk),
      .reset(rstN),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word-addressed memory model: combinational read gated by the read enable, write on the clock edge.
   assign bus.Read_Data = bus.DataMemory_Read ? mem[bus.Address[11:2]] : 32'h0;

   always @(posedge clk) begin
      if (preloadEn)
         mem[preloadIdx] <= preloadData;
      else if (bus.DataMemory_Write)
         mem[bus.Address[11:2]] <= bus.Write_Data;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertions++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic expectWrite(input logic [31:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      expQ.push_back(e);
   endtask

   task automatic preloadWord(input logic [9:0] idx, input logic [31:0] d);
      preloadEn   = 1'b1;
      preloadIdx  = idx;
      preloadData = d;
      @(negedge clk);
      preloadEn = 1'b0;
   endtask

   task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst,
                                input logic [15:0] len, input logic withAbort);
      bus.Src_Address = src;
      bus.Dst_Address = dst;
      bus.Length      = len;
      bus.start       = 1'b1;
      bus.abort       = withAbort;
   endtask

   // Counts cycles from the start edge to the done pulse; optionally re-pulses start at cycle injectAt.
   task automatic waitDone(input int expCycles, input string name, input int injectAt);
      int  cycles = 0;
      bit  seen = 0;
      while (cycles < 200 && !seen) begin
         @(negedge clk);
         cycles++;
         bus.abort = 1'b0;
         bus.start = (cycles == injectAt);
         if (cycles == injectAt) begin
            bus.Src_Address = 32'h200;
            bus.Dst_Address = 32'h900;
            bus.Length      = 16'd7;
         end
         if (bus.done) seen = 1;
      end
      if (!seen) checkOutput({name, " done timeout"}, 32'd0, 32'd1);
      else checkOutput({name, " cycles to done"}, cycles, expCycles);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Monitor: pops the scoreboard on every write and checks enable exclusivity and zero gating.
   always @(negedge clk) begin
      if (rstN) begin
         checkOutput("rd/wr exclusive", {31'd0, bus.DataMemory_Read & bus.DataMemory_Write}, 32'd0);
         if (bus.DataMemory_Read) begin
            readLog.push_back(bus.Address);
            readCount++;
         end else if (!bus.DataMemory_Write) begin
            checkOutput("idle address gating", bus.Address, 32'h0);
         end
         if (bus.DataMemory_Write) begin
            if (expQ.size() == 0) begin
               assertions++;
               failures++;
               $display("[TB] FAIL unexpected write: addr 0x%08h data 0x%08h, expected no write",
                        bus.Address, bus.Write_Data);
            end else begin
               wr_t e;
               e = expQ.pop_front();
               checkOutput("write address", bus.Address, e.addr);
               checkOutput("write data", bus.Write_Data, e.data);
            end
         end else begin
            checkOutput("write data gating", bus.Write_Data, 32'h0);
         end
         if (bus.done) doneCount++;
      end
   end

   // Directed sequence of copies covering normal, empty, abort, wrap, reset and busy-start cases.
   initial begin
      int cnt0;
      int wcount;
      int cyc;
      rstN = 1'b0;
      preloadEn = 1'b0;
      preloadIdx = '0;
      preloadData = '0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.Src_Address = '0;
      bus.Dst_Address = '0;
      bus.Length = '0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) preloadWord(10'(i), 32'(i + 1));
      for (int i = 0; i < 8; i++) preloadWord(10'(128 + i), 32'h11 + 32'(i));
      preloadWord(10'd195, 32'hDEADBEEF);
      preloadWord(10'd1023, 32'hAAAA0001);
      preloadWord(10'd321, 32'h5A5A5A5A);
      preloadWord(10'd576, 32'h5A5A5A5A);

      $display("[TB] reset state");
      checkOutput("reset busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("reset done", {31'd0, bus.done}, 32'd0);
      checkOutput("reset aborted", {31'd0, bus.aborted}, 32'd0);
      checkOutput("reset read enable", {31'd0, bus.DataMemory_Read}, 32'd0);
      checkOutput("reset write enable", {31'd0, bus.DataMemory_Write}, 32'd0);
      checkOutput("reset remaining", {16'd0, bus.Remaining}, 32'd0);
      rstN = 1'b1;
      @(negedge clk);

      $display("[TB] four-word copy 0x0 -> 0x100");
      for (int i = 0; i < 4; i++) expectWrite(32'h100 + 32'(4 * i), 32'(i + 1));
      applyStimulus(32'h0, 32'h100, 16'd4, 1'b0);
      waitDone(9, "copy4", 0);
      for (int i = 0; i < 4; i++) checkOutput("copy4 memory", mem[64 + i], 32'(i + 1));
      checkOutput("copy4 remaining", {16'd0, bus.Remaining}, 32'd0);
      checkOutput("copy4 busy after", {31'd0, bus.busy}, 32'd0);
`ifdef DMA_CHECKSUM_EN
      checkOutput("copy4 checksum", bus.Checksum, 32'd10);
`endif

      $display("[TB] zero-length copy");
      cnt0 = readCount;
      applyStimulus(32'h0, 32'h800, 16'd0, 1'b0);
      waitDone(1, "len0", 0);
      checkOutput("len0 no reads", 32'(readCount - cnt0), 32'd0);
      checkOutput("len0 remaining", {16'd0, bus.Remaining}, 32'd0);

      $display("[TB] abort in third write of eight");
      for (int i = 0; i < 3; i++) expectWrite(32'h300 + 32'(4 * i), 32'h11 + 32'(i));
      cnt0 = doneCount;
      applyStimulus(32'h200, 32'h300, 16'd8, 1'b0);
      wcount = 0;
      cyc = 0;
      while (cyc < 40 && wcount < 3) begin
         @(negedge clk);
         cyc++;
         bus.start = 1'b0;
         if (bus.DataMemory_Write) wcount++;
      end
      checkOutput("abort reached third write", 32'(wcount), 32'd3);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      checkOutput("abort busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("abort flag", {31'd0, bus.aborted}, 32'd1);
      checkOutput("abort remaining", {16'd0, bus.Remaining}, 32'd5);
      repeat (3) @(negedge clk);
      checkOutput("abort no done", 32'(doneCount - cnt0), 32'd0);
      checkOutput("abort third word", mem[194], 32'h13);
      checkOutput("abort fourth untouched", mem[195], 32'hDEADBEEF);
`ifdef DMA_CHECKSUM_EN
      checkOutput("abort checksum", bus.Checksum, 32'h36);
`endif

      $display("[TB] wrapping source with abort alongside start");
      expectWrite(32'h400, 32'hAAAA0001);
      expectWrite(32'h404, 32'h1);
      cnt0 = readLog.size();
      applyStimulus(32'hFFFFFFFC, 32'h400, 16'd2, 1'b1);
      waitDone(5, "wrap", 0);
      checkOutput("wrap aborted cleared", {31'd0, bus.aborted}, 32'd0);
      checkOutput("wrap read count", 32'(readLog.size() - cnt0), 32'd2);
      if (readLog.size() >= cnt0 + 2) checkOutput("wrap second read address", readLog[cnt0 + 1], 32'h0);
      checkOutput("wrap second word", mem[257], 32'h1);

      $display("[TB] reset during read of word 2");
      expectWrite(32'h500, 32'h1);
      applyStimulus(32'h0, 32'h500, 16'd4, 1'b0);
      wcount = 0;
      cyc = 0;
      while (cyc < 40 && wcount < 1) begin
         @(negedge clk);
         cyc++;
         bus.start = 1'b0;
         if (bus.DataMemory_Write) wcount++;
      end
      @(negedge clk);
      checkOutput("pre-reset in read", {31'd0, bus.DataMemory_Read}, 32'd1);
      rstN = 1'b0;
      #1;
      checkOutput("midreset busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("midreset read enable", {31'd0, bus.DataMemory_Read}, 32'd0);
      checkOutput("midreset write enable", {31'd0, bus.DataMemory_Write}, 32'd0);
      checkOutput("midreset address", bus.Address, 32'h0);
      checkOutput("midreset remaining", {16'd0, bus.Remaining}, 32'd0);
      repeat (2) @(negedge clk);
      checkOutput("midreset second word unwritten", mem[321], 32'h5A5A5A5A);
      rstN = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) expectWrite(32'h600 + 32'(4 * i), 32'(i + 1));
      applyStimulus(32'h0, 32'h600, 16'd4, 1'b0);
      waitDone(9, "post-reset copy", 0);
      for (int i = 0; i < 4; i++) checkOutput("post-reset memory", mem[384 + i], 32'(i + 1));

      $display("[TB] start while busy is ignored");
      for (int i = 0; i < 3; i++) expectWrite(32'h700 + 32'(4 * i), 32'(i + 1));
      applyStimulus(32'h0, 32'h700, 16'd3, 1'b0);
      waitDone(7, "busy-start", 3);
      checkOutput("busy-start remaining", {16'd0, bus.Remaining}, 32'd0);
      checkOutput("busy-start stray dst untouched", mem[576], 32'h5A5A5A5A);
`ifdef DMA_CHECKSUM_EN
      checkOutput("busy-start checksum", bus.Checksum, 32'd6);
`endif

      repeat (2) @(negedge clk);
      checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end
endmodule
